multi_cycle_control: RTL and testbench

MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

---
 rtl/multi_cycle_control_pkg.sv | 63 ++++++
 rtl/mcc_decode.sv | 65 ++++++
 rtl/multi_cycle_control.sv | 169 ++++++++++++++++
 tb/tb_multi_cycle_control.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/multi_cycle_control_pkg.sv
// Shared encodings for the multi-cycle controller: state codes, opcode/funct
// values, ALU operation codes and datapath mux selects (also used by ALU control).
package multi_cycle_control_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEMACC = 3'd3,
        S_WBACK  = 3'd4,
        S_BRJMP  = 3'd5,
        S_TRAP   = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        CLS_RTYPE   = 3'd0,
        CLS_LOAD    = 3'd1,
        CLS_STORE   = 3'd2,
        CLS_ITYPE   = 3'd3,
        CLS_BRANCH  = 3'd4,
        CLS_JUMP    = 3'd5,
        CLS_ILLEGAL = 3'd6
    } instr_class_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;

    // ALU_FUNC (all ones) tells ALU control to decode the funct field instead
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_LUI  = 4'd7;
    localparam logic [3:0] ALU_FUNC = 4'hF;

    localparam logic [1:0] SRCB_REG    = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

endpackage

// File: rtl/mcc_decode.sv
// Combinational instruction decode: opcode/funct to instruction class,
// immediate-form ALU operation, immediate extension mode and shift flag.
module mcc_decode
    import multi_cycle_control_pkg::*;
#(
    parameter int OPCODE_W = 6
) (
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [OPCODE_W-1:0] func_code,
    output logic [2:0]          instr_class,
    output logic [3:0]          imm_alu_op,
    output logic                imm_sign_ext,
    output logic                is_shift
);

    always_comb begin
        instr_class  = CLS_ILLEGAL;
        imm_alu_op   = ALU_ADD;
        imm_sign_ext = 1'b1;
        case (opcode)
            OPCODE_W'(OP_RTYPE): instr_class = CLS_RTYPE;
            OPCODE_W'(OP_J):     instr_class = CLS_JUMP;
            OPCODE_W'(OP_BEQ):   instr_class = CLS_BRANCH;
            OPCODE_W'(OP_LW):    instr_class = CLS_LOAD;
            OPCODE_W'(OP_SW):    instr_class = CLS_STORE;
            OPCODE_W'(OP_ADDI),
            OPCODE_W'(OP_ADDIU): instr_class = CLS_ITYPE;
            OPCODE_W'(OP_SLTI): begin
                instr_class = CLS_ITYPE;
                imm_alu_op  = ALU_SLT;
            end
            OPCODE_W'(OP_SLTIU): begin
                instr_class = CLS_ITYPE;
                imm_alu_op  = ALU_SLTU;
            end
            // Logical immediates and LUI take a zero-extended immediate
            OPCODE_W'(OP_ANDI): begin
                instr_class  = CLS_ITYPE;
                imm_alu_op   = ALU_AND;
                imm_sign_ext = 1'b0;
            end
            OPCODE_W'(OP_ORI): begin
                instr_class  = CLS_ITYPE;
                imm_alu_op   = ALU_OR;
                imm_sign_ext = 1'b0;
            end
            OPCODE_W'(OP_XORI): begin
                instr_class  = CLS_ITYPE;
                imm_alu_op   = ALU_XOR;
                imm_sign_ext = 1'b0;
            end
            OPCODE_W'(OP_LUI): begin
                instr_class  = CLS_ITYPE;
                imm_alu_op   = ALU_LUI;
                imm_sign_ext = 1'b0;
            end
            default: instr_class = CLS_ILLEGAL;
        endcase
    end

    assign is_shift = (func_code == OPCODE_W'(FN_SLL)) ||
                      (func_code == OPCODE_W'(FN_SRL)) ||
                      (func_code == OPCODE_W'(FN_SRA));

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle processor control FSM with combinational datapath controls.
// Define MULTI_CYCLE_CONTROL_TRAP_EN to trap illegal opcodes instead of treating them as NOPs.
module multi_cycle_control
    import multi_cycle_control_pkg::*;
#(
    parameter int OPCODE_W    = 6,
    parameter int ALUOP_W     = 4,
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic [OPCODE_W-1:0] Opcode,
    input  logic [OPCODE_W-1:0] FuncCode,
    input  logic                MemReady,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                IorD,
    output logic                IRWrite,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                RegDst,
    output logic                MemToReg,
    output logic                RegWrite,
    output logic                SignExtend,
    output logic                ALUSrcA,
    output logic                ALUSrc1,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          PCSource,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic [2:0]          State,
    output logic                IllegalOp
);

    state_e     state_q, state_d;
    logic [2:0] instr_class;
    logic [3:0] imm_alu_op;
    logic       imm_sign_ext;
    logic       is_shift;
    logic       mem_ok;

    mcc_decode #(.OPCODE_W(OPCODE_W)) u_decode (
        .opcode      (Opcode),
        .func_code   (FuncCode),
        .instr_class (instr_class),
        .imm_alu_op  (imm_alu_op),
        .imm_sign_ext(imm_sign_ext),
        .is_shift    (is_shift)
    );

    assign mem_ok = MEM_WAIT_EN ? MemReady : 1'b1;
    assign State  = state_q;

    always_comb begin
        state_d     = state_q;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        IRWrite     = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        RegDst      = 1'b0;
        MemToReg    = 1'b0;
        RegWrite    = 1'b0;
        SignExtend  = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrc1     = 1'b0;
        ALUSrcB     = SRCB_REG;
        PCSource    = PCSRC_ALU;
        ALUOp       = ALUOP_W'(ALU_ADD);
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = mem_ok;
                PCWrite = mem_ok;
                if (mem_ok) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB    = SRCB_IMM_SH;
                SignExtend = 1'b1;
                case (instr_class)
                    CLS_BRANCH, CLS_JUMP: state_d = S_BRJMP;
`ifdef MULTI_CYCLE_CONTROL_TRAP_EN
                    CLS_ILLEGAL:          state_d = S_TRAP;
`else
                    CLS_ILLEGAL:          state_d = S_FETCH;
`endif
                    default:              state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                if (instr_class == CLS_RTYPE) begin
                    ALUOp   = '1;
                    ALUSrc1 = is_shift;
                    state_d = S_WBACK;
                end else begin
                    ALUSrcB    = SRCB_IMM;
                    ALUOp      = ALUOP_W'(imm_alu_op);
                    SignExtend = imm_sign_ext;
                    state_d    = (instr_class == CLS_LOAD || instr_class == CLS_STORE) ? S_MEMACC : S_WBACK;
                end
            end
            S_MEMACC: begin
                IorD     = 1'b1;
                MemRead  = (instr_class == CLS_LOAD);
                MemWrite = (instr_class == CLS_STORE);
                if (mem_ok) state_d = (instr_class == CLS_LOAD) ? S_WBACK : S_FETCH;
            end
            S_WBACK: begin
                RegWrite = 1'b1;
                RegDst   = (instr_class == CLS_RTYPE);
                MemToReg = (instr_class == CLS_LOAD);
                state_d  = S_FETCH;
            end
            S_BRJMP: begin
                if (instr_class == CLS_BRANCH) begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = ALUOP_W'(ALU_SUB);
                    PCWriteCond = 1'b1;
                    PCSource    = PCSRC_ALUOUT;
                end else begin
                    PCWrite  = 1'b1;
                    PCSource = PCSRC_JUMP;
                end
                state_d = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
        // Reset must kill every strobe immediately, even before the state flop clears
        if (Reset) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IRWrite     = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            RegWrite    = 1'b0;
        end
    end

`ifdef MULTI_CYCLE_CONTROL_TRAP_EN
    logic illegal_q, illegal_d;

    always_comb begin
        illegal_d = illegal_q | (state_d == S_TRAP);
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    assign IllegalOp = illegal_q;
`else
    always_ff @(posedge CLK) begin
        if (Reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    assign IllegalOp = 1'b0;
`endif

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed bench for multi_cycle_control with hand-computed expectations.
module tb_multi_cycle_control;

    logic       CLK;
    logic       Reset;
    logic [5:0] Opcode;
    logic [5:0] FuncCode;
    logic       MemReady;
    logic       PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite;
    logic       RegDst, MemToReg, RegWrite, SignExtend, ALUSrcA, ALUSrc1;
    logic [1:0] ALUSrcB, PCSource;
    logic [3:0] ALUOp;
    logic [2:0] State;
    logic       IllegalOp;
    logic [5:0] strb;

    int vectors     = 0;
    int miscompares = 0;

    multi_cycle_control dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .Opcode     (Opcode),
        .FuncCode   (FuncCode),
        .MemReady   (MemReady),
        .PCWrite    (PCWrite),
        .PCWriteCond(PCWriteCond),
        .IorD       (IorD),
        .IRWrite    (IRWrite),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .RegDst     (RegDst),
        .MemToReg   (MemToReg),
        .RegWrite   (RegWrite),
        .SignExtend (SignExtend),
        .ALUSrcA    (ALUSrcA),
        .ALUSrc1    (ALUSrc1),
        .ALUSrcB    (ALUSrcB),
        .PCSource   (PCSource),
        .ALUOp      (ALUOp),
        .State      (State),
        .IllegalOp  (IllegalOp)
    );

    // Strobe bundle order: PCWrite PCWriteCond IRWrite MemRead MemWrite RegWrite
    assign strb = {PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, RegWrite};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input logic rdy);
        Opcode   = op;
        FuncCode = fn;
        MemReady = rdy;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        Reset = 1'b1;
        applyStimulus(6'h00, 6'h00, 1'b1);
        tick();
        tick();
        checkOutput("reset_state", 32'(State), 32'd0);
        checkOutput("reset_strobes", 32'(strb), 32'b000000);
        checkOutput("reset_illegal", 32'(IllegalOp), 32'd0);

        Reset = 1'b0;
        #1;
        checkOutput("fetch_strobes", 32'(strb), 32'b101100);
        checkOutput("fetch_srcb", 32'(ALUSrcB), 32'd1);
        checkOutput("fetch_aluop", 32'(ALUOp), 32'd0);

        // LW with one FETCH wait cycle first
        applyStimulus(6'h23, 6'h00, 1'b0);
        checkOutput("fetch_wait_strobes", 32'(strb), 32'b000100);
        tick();
        checkOutput("fetch_wait_state", 32'(State), 32'd0);
        applyStimulus(6'h23, 6'h00, 1'b1);
        checkOutput("fetch_go_strobes", 32'(strb), 32'b101100);
        tick();
        checkOutput("lw_decode_state", 32'(State), 32'd1);
        checkOutput("lw_decode_srcb", 32'(ALUSrcB), 32'd3);
        checkOutput("lw_decode_sext", 32'(SignExtend), 32'd1);
        checkOutput("lw_decode_strobes", 32'(strb), 32'b000000);
        tick();
        checkOutput("lw_exec_state", 32'(State), 32'd2);
        checkOutput("lw_exec_srca_srcb", 32'({ALUSrcA, ALUSrcB}), 32'b110);
        checkOutput("lw_exec_aluop", 32'(ALUOp), 32'd0);
        checkOutput("lw_exec_strobes", 32'(strb), 32'b000000);
        tick();
        checkOutput("lw_mem_state", 32'(State), 32'd3);
        checkOutput("lw_mem_iord", 32'(IorD), 32'd1);
        checkOutput("lw_mem_strobes", 32'(strb), 32'b000100);
        tick();
        checkOutput("lw_wb_state", 32'(State), 32'd4);
        checkOutput("lw_wb_strobes", 32'(strb), 32'b000001);
        checkOutput("lw_wb_dst_m2r", 32'({RegDst, MemToReg}), 32'b01);
        tick();
        checkOutput("lw_done_state", 32'(State), 32'd0);

        // SW with MemReady low in EXEC (ignored) and for 3 MEMACC cycles
        applyStimulus(6'h2B, 6'h00, 1'b1);
        tick();
        checkOutput("sw_decode_state", 32'(State), 32'd1);
        tick();
        applyStimulus(6'h2B, 6'h00, 1'b0);
        checkOutput("sw_exec_state", 32'(State), 32'd2);
        tick();
        checkOutput("sw_mem1_state", 32'(State), 32'd3);
        checkOutput("sw_mem1_strobes", 32'(strb), 32'b000010);
        tick();
        checkOutput("sw_mem2_state", 32'(State), 32'd3);
        checkOutput("sw_mem2_strobes", 32'(strb), 32'b000010);
        tick();
        checkOutput("sw_mem3_state", 32'(State), 32'd3);
        checkOutput("sw_mem3_strobes", 32'(strb), 32'b000010);
        tick();
        applyStimulus(6'h2B, 6'h00, 1'b1);
        checkOutput("sw_mem4_state", 32'(State), 32'd3);
        checkOutput("sw_mem4_strobes", 32'(strb), 32'b000010);
        tick();
        checkOutput("sw_done_state", 32'(State), 32'd0);

        // R-type SLL then ADD
        applyStimulus(6'h00, 6'h00, 1'b1);
        tick();
        tick();
        checkOutput("sll_exec_state", 32'(State), 32'd2);
        checkOutput("sll_exec_src", 32'({ALUSrcA, ALUSrc1, ALUSrcB}), 32'b1100);
        checkOutput("sll_exec_aluop", 32'(ALUOp), 32'hF);
        tick();
        checkOutput("sll_wb_state", 32'(State), 32'd4);
        checkOutput("sll_wb_dst_m2r", 32'({RegDst, MemToReg}), 32'b10);
        checkOutput("sll_wb_strobes", 32'(strb), 32'b000001);
        tick();
        applyStimulus(6'h00, 6'h20, 1'b1);
        tick();
        tick();
        checkOutput("add_exec_shamt", 32'(ALUSrc1), 32'd0);
        checkOutput("add_exec_aluop", 32'(ALUOp), 32'hF);
        tick();
        tick();
        checkOutput("add_done_state", 32'(State), 32'd0);

        // ORI: zero-extended immediate, OR operation, rt destination
        applyStimulus(6'h0D, 6'h00, 1'b1);
        tick();
        tick();
        checkOutput("ori_exec_srcb", 32'(ALUSrcB), 32'd2);
        checkOutput("ori_exec_sext", 32'(SignExtend), 32'd0);
        checkOutput("ori_exec_aluop", 32'(ALUOp), 32'd3);
        tick();
        checkOutput("ori_wb_dst", 32'(RegDst), 32'd0);
        tick();

        // BEQ and J, 3 cycles each
        applyStimulus(6'h04, 6'h00, 1'b1);
        tick();
        tick();
        checkOutput("beq_state", 32'(State), 32'd5);
        checkOutput("beq_strobes", 32'(strb), 32'b010000);
        checkOutput("beq_pcsrc", 32'(PCSource), 32'd1);
        checkOutput("beq_aluop", 32'(ALUOp), 32'd1);
        checkOutput("beq_srca_srcb", 32'({ALUSrcA, ALUSrcB}), 32'b100);
        tick();
        checkOutput("beq_done_state", 32'(State), 32'd0);
        applyStimulus(6'h02, 6'h00, 1'b1);
        tick();
        tick();
        checkOutput("j_state", 32'(State), 32'd5);
        checkOutput("j_strobes", 32'(strb), 32'b100000);
        checkOutput("j_pcsrc", 32'(PCSource), 32'd2);
        tick();
        checkOutput("j_done_state", 32'(State), 32'd0);

        // Illegal opcode 0x3F
        applyStimulus(6'h3F, 6'h00, 1'b1);
        tick();
        checkOutput("ill_decode_state", 32'(State), 32'd1);
        tick();
`ifdef MULTI_CYCLE_CONTROL_TRAP_EN
        checkOutput("ill_trap_state", 32'(State), 32'd6);
        checkOutput("ill_trap_flag", 32'(IllegalOp), 32'd1);
        checkOutput("ill_trap_strobes", 32'(strb), 32'b000000);
        tick();
        tick();
        checkOutput("ill_trap_hold_state", 32'(State), 32'd6);
        checkOutput("ill_trap_hold_flag", 32'(IllegalOp), 32'd1);
        Reset = 1'b1;
        tick();
        checkOutput("ill_reset_state", 32'(State), 32'd0);
        checkOutput("ill_reset_flag", 32'(IllegalOp), 32'd0);
        Reset = 1'b0;
        #1;
`else
        checkOutput("ill_nop_state", 32'(State), 32'd0);
        checkOutput("ill_nop_flag", 32'(IllegalOp), 32'd0);
        checkOutput("ill_nop_strobes", 32'(strb), 32'b101100);
`endif

        // Reset arriving mid-MEMACC while waiting on memory
        applyStimulus(6'h23, 6'h00, 1'b1);
        tick();
        tick();
        tick();
        applyStimulus(6'h23, 6'h00, 1'b0);
        checkOutput("rst_mem_state", 32'(State), 32'd3);
        tick();
        checkOutput("rst_mem_hold_state", 32'(State), 32'd3);
        Reset = 1'b1;
        #1;
        checkOutput("rst_mem_strobes", 32'(strb), 32'b000000);
        tick();
        checkOutput("rst_after_state", 32'(State), 32'd0);
        checkOutput("rst_after_strobes", 32'(strb), 32'b000000);
        Reset = 1'b0;
        applyStimulus(6'h23, 6'h00, 1'b1);
        checkOutput("rst_fetch_strobes", 32'(strb), 32'b101100);
        tick();
        checkOutput("rst_fetch_next_state", 32'(State), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
